pixel_upscaler_2x: RTL and testbench

PIXEL_UPSCALER_2X -- requirements
Module: pixel_upscaler_2x

---
 rtl/pixel_upscaler_2x.sv | 169 ++++++++++++++++
 tb/tb_pixel_upscaler_2x.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_upscaler_2x.sv
// pixel_upscaler_2x
// Reads a SRC_W x SRC_H 8-bit source image from a ROM in raster order and
// writes every source pixel as a 2x2 block into a destination RAM that is
// twice as wide and twice as tall.
//
// ROM timing assumed: ROM_DATA may be sampled on the second rising edge after
// ROM_ADDR changes (one registered read stage in the ROM).
//
// Build option: define UPSCALE_PREFETCH_EN to overlap the next source fetch
// with the last two writes of the current pixel (4 cycles/pixel instead of 6).
// The write sequence (addresses, data, order) is identical in both builds.
module pixel_upscaler_2x #(
  parameter int SRC_W = 160,
  parameter int SRC_H = 120
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  output logic [14:0] ROM_ADDR,
  input  logic [7:0]  ROM_DATA,
  output logic [16:0] RAM_ADDR,
  output logic [7:0]  RAM_DATA,
  output logic        RAM_WREN,
  output logic        BUSY,
  output logic        DONE
);

  localparam int SXW = (SRC_W > 1) ? $clog2(SRC_W) : 1;
  localparam int SYW = (SRC_H > 1) ? $clog2(SRC_H) : 1;

  localparam logic [SXW-1:0] SX_LAST  = SXW'(SRC_W - 1);
  localparam logic [SYW-1:0] SY_LAST  = SYW'(SRC_H - 1);
  // One destination row, and the base jump from the last pixel of a source
  // row to the first pixel of the next one (skip the odd destination row).
  localparam logic [16:0]    ROW2     = 17'(2 * SRC_W);
  localparam logic [16:0]    ROW_STEP = 17'(2 * SRC_W + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_WR0,
    S_WR1,
    S_WR2,
    S_WR3,
    S_FIN
  } state_t;

  state_t          state_q;
  logic [14:0]     rom_addr_q;
  logic [16:0]     ram_addr_q;
  logic [7:0]      ram_data_q;
  logic            ram_wren_q;
  logic            busy_q;
  logic            done_q;
  // Current source coordinates and the destination address of its top-left copy.
  logic [SXW-1:0]  sx_q;
  logic [SYW-1:0]  sy_q;
  logic [16:0]     base_q;

  logic            last_px_d;
  logic            row_end_d;
  logic [16:0]     base_d;
  logic [SXW-1:0]  sx_d;
  logic [SYW-1:0]  sy_d;
  logic [14:0]     rom_next_d;

  // Next-pixel bookkeeping: coordinates, destination base and ROM address.
  always_comb begin
    row_end_d  = (sx_q == SX_LAST);
    last_px_d  = row_end_d && (sy_q == SY_LAST);
    base_d     = row_end_d ? (base_q + ROW_STEP) : (base_q + 17'd2);
    sx_d       = row_end_d ? '0 : (sx_q + SXW'(1));
    sy_d       = row_end_d ? (sy_q + SYW'(1)) : sy_q;
    rom_next_d = rom_addr_q + 15'd1;
  end

  // Sequencer: state, counters and all registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      rom_addr_q <= '0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      ram_wren_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sx_q       <= '0;
      sy_q       <= '0;
      base_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (START) begin
            state_q    <= S_FETCH;
            busy_q     <= 1'b1;
            rom_addr_q <= '0;
            sx_q       <= '0;
            sy_q       <= '0;
            base_q     <= '0;
          end
        end
        S_FETCH: state_q <= S_WAIT;
        S_WAIT: begin
          state_q    <= S_WR0;
          ram_data_q <= ROM_DATA;
          ram_addr_q <= base_q;
          ram_wren_q <= 1'b1;
        end
        S_WR0: begin
          state_q    <= S_WR1;
          ram_addr_q <= base_q + 17'd1;
        end
        S_WR1: begin
          state_q    <= S_WR2;
          ram_addr_q <= base_q + ROW2;
`ifdef UPSCALE_PREFETCH_EN
          // Launch the next read now so its data is ready on entry to WR0.
          if (!last_px_d) begin
            rom_addr_q <= rom_next_d;
          end
`endif
        end
        S_WR2: begin
          state_q    <= S_WR3;
          ram_addr_q <= base_q + ROW2 + 17'd1;
        end
        S_WR3: begin
          if (last_px_d) begin
            state_q    <= S_FIN;
            ram_wren_q <= 1'b0;
            done_q     <= 1'b1;
          end else begin
            sx_q   <= sx_d;
            sy_q   <= sy_d;
            base_q <= base_d;
`ifdef UPSCALE_PREFETCH_EN
            state_q    <= S_WR0;
            ram_data_q <= ROM_DATA;
            ram_addr_q <= base_d;
`else
            state_q    <= S_FETCH;
            ram_wren_q <= 1'b0;
            rom_addr_q <= rom_next_d;
`endif
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q    <= S_IDLE;
          ram_wren_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign ROM_ADDR = rom_addr_q;
  assign RAM_ADDR = ram_addr_q;
  assign RAM_DATA = ram_data_q;
  assign RAM_WREN = ram_wren_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;

endmodule

// File: tb/tb_pixel_upscaler_2x.sv
// Testbench for pixel_upscaler_2x on a 4x2 source image. A reference model
// enumerates the destination 2x2 blocks per source pixel into a queue; a
// monitor pops and compares on every RAM write.
module tb_pixel_upscaler_2x;

  localparam int W    = 4;
  localparam int H    = 2;
  localparam int NPIX = W * H;
  localparam int NWR  = 4 * NPIX;
  localparam int MAXA = NWR - 1;
`ifdef UPSCALE_PREFETCH_EN
  localparam int DONE_REL = 4 * NPIX + 3;
`else
  localparam int DONE_REL = 6 * NPIX + 1;
`endif

  logic        CLK;
  logic        RESET;
  logic        START;
  logic [14:0] ROM_ADDR;
  logic [7:0]  ROM_DATA;
  logic [16:0] RAM_ADDR;
  logic [7:0]  RAM_DATA;
  logic        RAM_WREN;
  logic        BUSY;
  logic        DONE;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int start_cyc = 0;
  int wr_cnt    = 0;
  int done_cnt  = 0;
  int done_rel  = 0;
  int first_rel = 0;

  logic [7:0]  rom [0:NPIX-1];
  logic [7:0]  ram [0:NWR-1];
  logic [24:0] exp_q [$];

  pixel_upscaler_2x #(.SRC_W(W), .SRC_H(H)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .START    (START),
    .ROM_ADDR (ROM_ADDR),
    .ROM_DATA (ROM_DATA),
    .RAM_ADDR (RAM_ADDR),
    .RAM_DATA (RAM_DATA),
    .RAM_WREN (RAM_WREN),
    .BUSY     (BUSY),
    .DONE     (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // ROM with one registered read stage.
  always @(posedge CLK) begin
    if (int'(ROM_ADDR) < NPIX) ROM_DATA <= rom[int'(ROM_ADDR)];
    else                        ROM_DATA <= 8'hxx;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: each source pixel becomes a 2x2 block, TL,TR,BL,BR.
  task automatic push_run();
    for (int sy = 0; sy < H; sy++)
      for (int sx = 0; sx < W; sx++)
        for (int k = 0; k < 4; k++) begin
          int dx, dy, a;
          dx = 2 * sx + (k % 2);
          dy = 2 * sy + (k / 2);
          a  = dy * (2 * W) + dx;
          exp_q.push_back({17'(a), rom[sy * W + sx]});
        end
  endtask

  // Monitor: compare every write against the scoreboard, track DONE.
  always @(negedge CLK) begin
    if (RAM_WREN === 1'b1) begin
      logic [24:0] e;
      if (wr_cnt == 0) first_rel = cyc - start_cyc + 1;
      wr_cnt++;
      chk("addr_in_range", 32'(int'(RAM_ADDR) <= MAXA), 32'd1);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_write: got addr %0d data %0d expected no write", RAM_ADDR, RAM_DATA);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(RAM_ADDR), 32'(e[24:8]));
        chk("wr_data", 32'(RAM_DATA), 32'(e[7:0]));
      end
      if (int'(RAM_ADDR) < NWR) ram[int'(RAM_ADDR)] = RAM_DATA;
      $display("write #%0d addr=%0d data=%0d", wr_cnt, RAM_ADDR, RAM_DATA);
    end
    if (DONE === 1'b1) begin
      done_cnt++;
      done_rel = cyc - start_cyc + 1;
    end
  end

  task automatic pulse_start();
    @(negedge CLK);
    START = 1'b1;
    @(posedge CLK);
    #1;
    start_cyc = cyc;
    START = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int i;
    i = 0;
    while (done_cnt < target && i < budget) begin
      @(posedge CLK);
      #1;
      i++;
    end
    if (done_cnt < target) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got done_cnt %0d expected %0d", name, done_cnt, target);
    end
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < NPIX; i++) rom[i] = 8'(i + 10);
  endtask

  task automatic new_run();
    for (int i = 0; i < NWR; i++) ram[i] = 8'h00;
    wr_cnt   = 0;
    done_cnt = 0;
  endtask

  task automatic check_run(input string name);
    repeat (5) @(negedge CLK);
    chk({name, "_writes"}, 32'(wr_cnt), 32'(NWR));
    chk({name, "_done_cnt"}, 32'(done_cnt), 32'd1);
    chk({name, "_done_cycle"}, 32'(done_rel), 32'(DONE_REL));
    chk({name, "_first_wr_cycle"}, 32'(first_rel), 32'd3);
    chk({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_busy_idle"}, 32'(BUSY), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1;
    START = 1'b0;
    fill_ramp();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_wren", 32'(RAM_WREN), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_rom_addr", 32'(ROM_ADDR), 32'd0);
    chk("rst_ram_addr", 32'(RAM_ADDR), 32'd0);
    chk("rst_ram_data", 32'(RAM_DATA), 32'd0);
    RESET = 1'b0;
    repeat (2) @(negedge CLK);

    // Basic ramp image.
    new_run();
    push_run();
    pulse_start();
    wait_done(1, 200, "ramp");
    check_run("ramp");
    chk("ram0", 32'(ram[0]), 32'd10);
    chk("ram1", 32'(ram[1]), 32'd10);
    chk("ram8", 32'(ram[8]), 32'd10);
    chk("ram9", 32'(ram[9]), 32'd10);
    chk("ram22", 32'(ram[22]), 32'd17);
    chk("ram23", 32'(ram[23]), 32'd17);
    chk("ram30", 32'(ram[30]), 32'd17);
    chk("ram31", 32'(ram[31]), 32'd17);

    // START re-pulsed at cycle 10 must be ignored.
    new_run();
    push_run();
    pulse_start();
    repeat (9) @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    wait_done(1, 200, "repulse");
    check_run("repulse");

    // Random images with random idle gaps.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NPIX; i++) rom[i] = 8'($urandom);
      repeat ($urandom_range(0, 5)) @(negedge CLK);
      new_run();
      push_run();
      pulse_start();
      wait_done(1, 200, "rand");
      check_run("rand");
    end

    // START held through FIN: a second run starts immediately.
    for (int i = 0; i < NPIX; i++) rom[i] = 8'($urandom);
    new_run();
    push_run();
    push_run();
    @(negedge CLK);
    START = 1'b1;
    wait_done(1, 200, "held1");
    repeat (4) @(negedge CLK);
    START = 1'b0;
    wait_done(2, 200, "held2");
    repeat (5) @(negedge CLK);
    chk("held_writes", 32'(wr_cnt), 32'(2 * NWR));
    chk("held_done_cnt", 32'(done_cnt), 32'd2);
    chk("held_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset mid-run aborts; next start restarts from pixel 0.
    fill_ramp();
    new_run();
    push_run();
    pulse_start();
    repeat (19) @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    chk("abort_wren", 32'(RAM_WREN), 32'd0);
    chk("abort_busy", 32'(BUSY), 32'd0);
    chk("abort_done", 32'(DONE), 32'd0);
    RESET = 1'b0;
    exp_q.delete();
    new_run();
    push_run();
    pulse_start();
    wait_done(1, 200, "restart");
    check_run("restart");
    chk("restart_ram0", 32'(ram[0]), 32'd10);

    // RESET wins over START on the same edge.
    new_run();
    @(negedge CLK);
    RESET = 1'b1;
    START = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    chk("rst_start_busy", 32'(BUSY), 32'd0);
    RESET = 1'b0;
    START = 1'b0;
    repeat (10) @(negedge CLK);
    chk("rst_start_busy_later", 32'(BUSY), 32'd0);
    chk("rst_start_no_writes", 32'(wr_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
